// File: rtl/crc16_frame_ctrl.sv
// crc16_frame_ctrl: byte-fed, bit-serial CRC-16 (x^16+x^15+x^2+1) frame controller.
// Define CRC16_CHECK_EN to add the crc_ok output (zero-residue check on appended CRC).
module crc16_frame_ctrl #(
    parameter logic [15:0] SEED = 16'h0000
) (
    input  logic        Clk,
    input  logic        R,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [15:0] crc_out,
    output logic        crc_valid,
    input  logic        crc_ready,
`ifdef CRC16_CHECK_EN
    output logic        crc_ok,
`endif
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nx;
    logic [15:0] c;
    logic [15:0] c_nx;
    logic [7:0]  sbuf;
    logic [2:0]  cnt;
    logic        last_q;
    logic        first_q;
    logic        fb;

    // one CRC step: feedback bit is the incoming message bit xor c15, fed to taps 0, 2 and 15
    always_comb begin
        fb   = sbuf[7] ^ c[15];
        c_nx = {c[14:0], fb} ^ (fb ? 16'h8004 : 16'h0000);
    end

    // next state and handshake outputs
    always_comb begin
        state_nx  = state;
        s_ready   = (state == IDLE);
        crc_valid = (state == DONE);
        busy      = (state != IDLE);
        crc_out   = c;
        case (state)
            IDLE:    state_nx = s_valid ? SHIFT : IDLE;
            SHIFT:   state_nx = (cnt == 3'd7) ? (last_q ? DONE : IDLE) : SHIFT;
            DONE:    state_nx = crc_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // state, CRC register, byte buffer, bit counter and frame-start flag
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state   <= IDLE;
            c       <= SEED;
            sbuf    <= 8'h00;
            cnt     <= 3'd0;
            last_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && s_valid) begin
                sbuf    <= s_data;
                last_q  <= s_last;
                cnt     <= 3'd0;
                first_q <= 1'b0;
                if (first_q)
                    c <= SEED;
            end else if (state == SHIFT) begin
                c    <= c_nx;
                sbuf <= {sbuf[6:0], 1'b0};
                cnt  <= cnt + 3'd1;
            end else if (state == DONE && crc_ready) begin
                first_q <= 1'b1;
            end
        end
    end

`ifdef CRC16_CHECK_EN
    assign crc_ok = (c == 16'h0000) && crc_valid;
`endif

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// tb_crc16_frame_ctrl: vector table plus hand sequences, results checked through an expected-CRC queue.
module tb_crc16_frame_ctrl;
    localparam logic [15:0] SEED = 16'h0000;
    localparam logic [71:0] MSG  = 72'h313233343536373839;

    logic        Clk = 1'b0;
    logic        R = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [15:0] crc_out;
    logic        crc_valid;
    logic        crc_ready = 1'b0;
    logic        busy;
`ifdef CRC16_CHECK_EN
    logic        crc_ok;
`endif

    crc16_frame_ctrl #(.SEED(SEED)) dut (
        .Clk(Clk),
        .R(R),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .crc_out(crc_out),
        .crc_valid(crc_valid),
        .crc_ready(crc_ready),
`ifdef CRC16_CHECK_EN
        .crc_ok(crc_ok),
`endif
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          len;
        logic [95:0] data;
        logic [15:0] want;
        int          gap;
    } vec_t;

    vec_t        vecs[8];
    logic [15:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          first_acc = 0;
    int          lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, input bit first);
        int n;
        s_data  = b;
        s_last  = l;
        s_valid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge Clk);
            if (s_ready) break;
        end
        check("accept_timeout", 32'(n < 100), 32'h1);
        if (first) first_acc = cyc;
        @(posedge Clk);
        #1;
    endtask

    task automatic send_frame(input logic [95:0] d, input int len, input int gap, input logic [15:0] want);
        sb.push_back(want);
        for (int i = 0; i < len; i++) begin
            if (i > 0 && gap > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, gap)) @(posedge Clk);
                #1;
            end
            send_byte(d[95-8*i -: 8], i == len - 1, i == 0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge Clk);
            if (crc_valid) break;
        end
        check("valid_timeout", 32'(n < 300), 32'h1);
        l = cyc - first_acc;
    endtask

    task automatic take_result(input string name);
        crc_ready = 1'b1;
        check({name, "_pending"}, 32'(sb.size() > 0), 32'h1);
        if (sb.size() > 0) check(name, 32'(crc_out), 32'(sb.pop_front()));
        @(posedge Clk);
        #1;
        check({name, "_released"}, 32'(crc_valid), 32'h0);
        check({name, "_idle"}, 32'(s_ready), 32'h1);
    endtask

    initial begin
        vecs[0] = '{len: 1, data: {8'h01, 88'h0},  want: 16'h8005, gap: 0};
        vecs[1] = '{len: 1, data: {8'h02, 88'h0},  want: 16'h800F, gap: 0};
        vecs[2] = '{len: 1, data: {8'h03, 88'h0},  want: 16'h000A, gap: 0};
        vecs[3] = '{len: 1, data: {8'h00, 88'h0},  want: 16'h0000, gap: 0};
        vecs[4] = '{len: 2, data: {16'h0001, 80'h0}, want: 16'h8005, gap: 0};
        vecs[5] = '{len: 2, data: {16'h0100, 80'h0}, want: 16'h8603, gap: 0};
        vecs[6] = '{len: 9, data: {MSG, 24'h0},   want: 16'hFEE8, gap: 0};
        vecs[7] = '{len: 9, data: {MSG, 24'h0},   want: 16'hFEE8, gap: 5};

        #12;
        check("rst_s_ready", 32'(s_ready), 32'h1);
        check("rst_crc_valid", 32'(crc_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_crc_out", 32'(crc_out), 32'(SEED));
        @(negedge Clk) R = 1'b1;
        @(posedge Clk);
        #1;
        check("post_rst_s_ready", 32'(s_ready), 32'h1);
        check("post_rst_busy", 32'(busy), 32'h0);

        crc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].len, vecs[i].gap, vecs[i].want);
            wait_valid(lat);
            if (vecs[i].len == 1) check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
            if (vecs[i].len == 9 && vecs[i].gap == 0) check($sformatf("vec%0d_latency", i), 32'(lat), 32'd81);
            take_result($sformatf("vec%0d", i));
        end

        crc_ready = 1'b0;
        send_frame({MSG, 24'h0}, 9, 0, 16'hFEE8);
        wait_valid(lat);
        check("hold_latency", 32'(lat), 32'd81);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        s_last  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("hold_valid", 32'(crc_valid), 32'h1);
            check("hold_crc", 32'(crc_out), 32'hFEE8);
            check("hold_s_ready", 32'(s_ready), 32'h0);
            @(negedge Clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        take_result("hold");
        send_frame({8'h01, 88'h0}, 1, 0, 16'h8005);
        wait_valid(lat);
        take_result("after_hold");

        send_byte(8'h31, 1'b0, 1'b1);
        send_byte(8'h32, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        s_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        check("mid_byte_busy", 32'(busy), 32'h1);
        R = 1'b0;
        #1;
        check("async_rst_s_ready", 32'(s_ready), 32'h1);
        check("async_rst_crc_valid", 32'(crc_valid), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_crc_out", 32'(crc_out), 32'(SEED));
        @(negedge Clk) R = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge Clk);
                if (crc_valid || busy) seen++;
            end
            check("no_partial_result", 32'(seen), 32'h0);
        end
        send_frame({8'h01, 88'h0}, 1, 0, 16'h8005);
        wait_valid(lat);
        take_result("after_reset");

`ifdef CRC16_CHECK_EN
        crc_ready = 1'b0;
        send_frame({MSG, 8'hFE, 8'hE8, 8'h00}, 11, 0, 16'h0000);
        wait_valid(lat);
        check("crc_ok_good", 32'(crc_ok), 32'h1);
        take_result("append_good");
        crc_ready = 1'b0;
        send_frame({MSG, 8'hFE, 8'hE9, 8'h00}, 11, 0, 16'h8005);
        wait_valid(lat);
        check("crc_ok_bad", 32'(crc_ok), 32'h0);
        take_result("append_bad");
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
